// File: rtl/counter_sequence_checker_pkg.sv
// Shared mode codes and checker state encoding for the counter sequence checker
// and the counter's next-value predictor.
package counter_sequence_checker_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_GRAY = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACQUIRE = 2'b01,
    ST_LOCKED  = 2'b10
  } state_e;

endpackage

// File: rtl/counter_sequence_checker_next.sv
// Combinational predictor: the value the counter should show one step after
// `value` in the given mode. Wrap-around in every mode is normal behaviour.
module count_next_value
  import counter_sequence_checker_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_value
);

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_inc;

  always_comb begin
    bin = '0;
    bin[WIDTH-1] = value[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ value[i];
    end
    bin_inc = bin + WIDTH'(1);

    next_value = value;
    case (mode)
      MODE_HOLD: next_value = value;
      MODE_UP:   next_value = value + WIDTH'(1);
      MODE_DOWN: next_value = value - WIDTH'(1);
      default:   next_value = bin_inc ^ (bin_inc >> 1);
    endcase
  end

endmodule

// File: rtl/counter_sequence_checker.sv
// Receive-side checker for the counter stream: predicts each next sample, locks
// after a clean run, then strobes and counts every deviation while locked.
//
// state      | meaning
// ST_IDLE    | no sample seen since reset; first enabled sample seeds the prediction
// ST_ACQUIRE | counting consecutive correct samples toward LOCK_COUNT
// ST_LOCKED  | stream trusted; mismatches strobe err_pulse and bump err_count
module counter_sequence_checker
  import counter_sequence_checker_pkg::*;
#(
  parameter int WIDTH      = 2,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_LIMIT  = 2,
  parameter int ERRCNT_W   = 8
) (
  input  logic                clock,
  input  logic                Reset,
  input  logic                En,
  input  logic [1:0]          select,
  input  logic [WIDTH-1:0]    Counter_In,
  output logic                locked,
  output logic                err_pulse,
  output logic [ERRCNT_W-1:0] err_count,
  output logic [WIDTH-1:0]    expected
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int NW = $clog2(ERR_LIMIT + 1);

  state_e              state_q, state_d;
  logic [MW-1:0]       match_q, match_d;
  logic [NW-1:0]       miss_q, miss_d;
  logic [1:0]          select_q, select_d;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;
  logic [WIDTH-1:0]    expected_q, expected_d;
  logic                err_pulse_q, err_pulse_d;
  logic                locked_q, locked_d;
  logic [WIDTH-1:0]    next_value;
  logic                hit;

  count_next_value #(.WIDTH(WIDTH)) u_next (
    .value      (Counter_In),
    .mode       (select),
    .next_value (next_value)
  );

  assign hit = (Counter_In == expected_q);

  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    miss_d      = miss_q;
    select_d    = select_q;
    err_count_d = err_count_q;
    expected_d  = expected_q;
    err_pulse_d = 1'b0;

    if (En) begin
      select_d   = select;
      expected_d = next_value;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQUIRE;
          match_d = MW'(1);
          miss_d  = '0;
        end
        default: begin
          // A mode change restarts acquisition and outranks the compare.
          if (select != select_q) begin
            state_d = ST_ACQUIRE;
            match_d = MW'(1);
            miss_d  = '0;
          end else if (state_q == ST_ACQUIRE) begin
            if (hit) begin
              match_d = match_q + MW'(1);
              if (match_q == MW'(LOCK_COUNT - 1)) begin
                state_d = ST_LOCKED;
                miss_d  = '0;
              end
            end else begin
              match_d = MW'(1);
            end
          end else if (hit) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + ERRCNT_W'(1);
            miss_d = miss_q + NW'(1);
            if (miss_q == NW'(ERR_LIMIT - 1)) begin
              state_d = ST_ACQUIRE;
              match_d = MW'(1);
              miss_d  = '0;
            end
          end
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      match_q     <= '0;
      miss_q      <= '0;
      select_q    <= '0;
      err_count_q <= '0;
      expected_q  <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      select_q    <= select_d;
      err_count_q <= err_count_d;
      expected_q  <= expected_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign expected  = expected_q;

endmodule

// File: tb/tb_counter_sequence_checker.sv
// Directed bench for counter_sequence_checker: default instance for sequencing
// scenarios, a second instance with a large ERR_LIMIT for error-count saturation.
module tb_counter_sequence_checker;
  import counter_sequence_checker_pkg::*;

  logic       clock = 1'b0;
  logic       Reset = 1'b0;
  logic       en = 1'b0, en2 = 1'b0;
  logic [1:0] sel = 2'b00, sel2 = 2'b00;
  logic [1:0] cin = 2'b00, cin2 = 2'b00;
  logic       locked, err_pulse, locked2, err_pulse2;
  logic [7:0] err_count, err_count2;
  logic [1:0] expected, expected2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  counter_sequence_checker u_dut (
    .clock(clock), .Reset(Reset), .En(en), .select(sel), .Counter_In(cin),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .expected(expected)
  );

  counter_sequence_checker #(.ERR_LIMIT(1000)) u_sat (
    .clock(clock), .Reset(Reset), .En(en2), .select(sel2), .Counter_In(cin2),
    .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2), .expected(expected2)
  );

  task automatic step(input logic [1:0] s, input logic [1:0] v);
    @(negedge clock);
    en = 1'b1; sel = s; cin = v;
    @(posedge clock);
    #1;
    en = 1'b0;
  endtask

  task automatic step2(input logic [1:0] s, input logic [1:0] v);
    @(negedge clock);
    en2 = 1'b1; sel2 = s; cin2 = v;
    @(posedge clock);
    #1;
    en2 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    en = 1'b0; en2 = 1'b0; Reset = 1'b0;
    @(negedge clock);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b want 0", locked); end
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse got %b want 0", err_pulse); end
    n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL reset_err_count got %h want 00", err_count); end
    n_checks++; if (expected !== 2'b00) begin n_fail++; $display("FAIL reset_expected got %b want 00", expected); end
    n_checks++; if (u_dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want IDLE", u_dut.state_q); end
    @(negedge clock);
    Reset = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [1:0] seq [10];
    seq = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
    do_reset();
    for (int i = 0; i < 4; i++) step(MODE_HOLD, 2'b00);
    for (int i = 0; i < 10; i++) step(MODE_HOLD, seq[i]);
    n_checks++; if (err_count !== 8'd5) begin n_fail++; $display("FAIL mid_pre_err_count got %0d want 5", err_count); end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL mid_pre_locked got %b want 1", locked); end
    @(negedge clock);
    #2 Reset = 1'b0;
    #1;
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mid_locked got %b want 0", locked); end
    n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL mid_err_count got %h want 00", err_count); end
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL mid_err_pulse got %b want 0", err_pulse); end
    n_checks++; if (expected !== 2'b00) begin n_fail++; $display("FAIL mid_expected got %b want 00", expected); end
    n_checks++; if (u_dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL mid_state got %0d want IDLE", u_dut.state_q); end
    @(negedge clock);
    Reset = 1'b1;
    step(MODE_UP, 2'b01);
    n_checks++; if (expected !== 2'b10) begin n_fail++; $display("FAIL first_sample_expected got %b want 10", expected); end
    n_checks++; if (u_dut.state_q !== ST_ACQUIRE) begin n_fail++; $display("FAIL first_sample_state got %0d want ACQUIRE", u_dut.state_q); end
  endtask

  task automatic test_up_lock();
    logic [1:0] seq [5];
    logic       want_lock [5];
    seq       = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    want_lock = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(MODE_UP, seq[i]);
      n_checks++; if (locked !== want_lock[i]) begin n_fail++; $display("FAIL up_locked[%0d] got %b want %b", i, locked, want_lock[i]); end
      n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL up_err_pulse[%0d] got %b want 0", i, err_pulse); end
    end
    n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL up_err_count got %h want 00", err_count); end
    n_checks++; if (expected !== 2'b01) begin n_fail++; $display("FAIL up_expected got %b want 01", expected); end
  endtask

  task automatic test_down_errors();
    logic [1:0] seq [6];
    logic       want_ep [6];
    logic [7:0] want_cnt [6];
    logic       want_lock [6];
    seq       = '{2'b11, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00};
    want_ep   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    want_cnt  = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3};
    want_lock = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    step(MODE_DOWN, 2'b11); step(MODE_DOWN, 2'b10); step(MODE_DOWN, 2'b01); step(MODE_DOWN, 2'b00);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL down_lock got %b want 1", locked); end
    for (int i = 0; i < 6; i++) begin
      step(MODE_DOWN, seq[i]);
      n_checks++; if (err_pulse !== want_ep[i]) begin n_fail++; $display("FAIL down_err_pulse[%0d] got %b want %b", i, err_pulse, want_ep[i]); end
      n_checks++; if (err_count !== want_cnt[i]) begin n_fail++; $display("FAIL down_err_count[%0d] got %0d want %0d", i, err_count, want_cnt[i]); end
      n_checks++; if (locked !== want_lock[i]) begin n_fail++; $display("FAIL down_locked[%0d] got %b want %b", i, locked, want_lock[i]); end
    end
    step(MODE_DOWN, 2'b00);
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL down_acquire_err_pulse got %b want 0", err_pulse); end
  endtask

  task automatic test_mode_change();
    do_reset();
    step(MODE_UP, 2'b00); step(MODE_UP, 2'b01); step(MODE_UP, 2'b10); step(MODE_UP, 2'b11);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL mode_pre_lock got %b want 1", locked); end
    step(MODE_GRAY, 2'b01);
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL mode_err_pulse got %b want 0", err_pulse); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mode_locked got %b want 0", locked); end
    n_checks++; if (expected !== 2'b11) begin n_fail++; $display("FAIL mode_expected got %b want 11", expected); end
    n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL mode_err_count got %h want 00", err_count); end
    step(MODE_GRAY, 2'b11);
    n_checks++; if (expected !== 2'b10) begin n_fail++; $display("FAIL gray_expected_a got %b want 10", expected); end
    step(MODE_GRAY, 2'b10);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL gray_locked_early got %b want 0", locked); end
    n_checks++; if (expected !== 2'b00) begin n_fail++; $display("FAIL gray_expected_b got %b want 00", expected); end
    step(MODE_GRAY, 2'b00);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL gray_locked got %b want 1", locked); end
    n_checks++; if (expected !== 2'b01) begin n_fail++; $display("FAIL gray_expected_c got %b want 01", expected); end
  endtask

  task automatic test_freeze();
    step(MODE_GRAY, 2'b10);
    n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL freeze_pre_err_pulse got %b want 1", err_pulse); end
    n_checks++; if (expected !== 2'b00) begin n_fail++; $display("FAIL freeze_pre_expected got %b want 00", expected); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      en = 1'b0; sel = 2'($urandom_range(3)); cin = 2'($urandom_range(3));
      @(posedge clock);
      #1;
      n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL freeze_err_pulse[%0d] got %b want 0", i, err_pulse); end
      n_checks++; if (expected !== 2'b00) begin n_fail++; $display("FAIL freeze_expected[%0d] got %b want 00", i, expected); end
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL freeze_locked[%0d] got %b want 1", i, locked); end
      n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL freeze_err_count[%0d] got %0d want 1", i, err_count); end
    end
    step(MODE_GRAY, 2'b00);
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL freeze_resume_err_pulse got %b want 0", err_pulse); end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL freeze_resume_locked got %b want 1", locked); end
  endtask

  task automatic test_err_saturation();
    int model;
    do_reset();
    for (int i = 0; i < 4; i++) step2(MODE_HOLD, 2'b00);
    n_checks++; if (locked2 !== 1'b1) begin n_fail++; $display("FAIL sat_lock got %b want 1", locked2); end
    model = 0;
    for (int i = 0; i < 259; i++) begin
      step2(MODE_HOLD, (i % 2 == 0) ? 2'b01 : 2'b00);
      if (model < 255) model++;
      n_checks++; if (err_count2 !== 8'(model)) begin n_fail++; $display("FAIL sat_err_count[%0d] got %0d want %0d", i, err_count2, model); end
      n_checks++; if (err_pulse2 !== 1'b1) begin n_fail++; $display("FAIL sat_err_pulse[%0d] got %b want 1", i, err_pulse2); end
    end
    n_checks++; if (err_count2 !== 8'hFF) begin n_fail++; $display("FAIL sat_final got %h want ff", err_count2); end
    n_checks++; if (locked2 !== 1'b1) begin n_fail++; $display("FAIL sat_locked got %b want 1", locked2); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid();
    test_up_lock();
    test_down_errors();
    test_mode_change();
    test_freeze();
    test_err_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
